// File: rtl/l0_input_buffer.sv
// Row-parallel input staging buffer: one SRAM word per cycle split into per-row FIFOs, drained as pop waves.
// Optional macro L0_SKEW_EN adds the diagonal skew (row k pops k cycles after the wave launch).
module l0_input_buffer #(
  parameter int bw    = 4,
  parameter int row   = 8,
  parameter int depth = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic [row*bw-1:0]   in,
  input  logic                rd,
  output logic [row*bw-1:0]   out,
  output logic [row-1:0]      o_valid,
  output logic                o_full,
  output logic                o_ready,
  output logic                o_empty
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [bw-1:0]     mem_q  [row][depth];
  logic [AW:0]       wptr_q [row];
  logic [AW:0]       wptr_d [row];
  logic [AW:0]       rptr_q [row];
  logic [AW:0]       rptr_d [row];
  logic [row*bw-1:0] out_q, out_d;
  logic [row-1:0]    valid_q, valid_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              wr_en;
  logic [row-1:0]    pop_req;
  logic [row-1:0]    pop;

`ifdef L0_SKEW_EN
  // Token for row k is rd delayed by k cycles; row 0 uses rd directly.
  logic [row-2:0] tok_q, tok_d;

  always_comb begin
    tok_d = '0;
    tok_d[0] = rd;
    for (int unsigned k = 1; k < row - 1; k++) begin
      tok_d[k] = tok_q[k-1];
    end
    pop_req = {tok_q, rd};
  end

  always_ff @(posedge clk) begin
    if (reset) tok_q <= '0;
    else       tok_q <= tok_d;
  end
`else
  always_comb begin
    pop_req = {row{rd}};
  end
`endif

  always_comb begin
    wr_en   = wr && !full_q;
    pop     = '0;
    out_d   = out_q;
    full_d  = 1'b0;
    empty_d = 1'b1;
    for (int unsigned k = 0; k < row; k++) begin
      pop[k]    = pop_req[k] && (wptr_q[k] != rptr_q[k]);
      wptr_d[k] = wr_en  ? wptr_q[k] + PTR_ONE : wptr_q[k];
      rptr_d[k] = pop[k] ? rptr_q[k] + PTR_ONE : rptr_q[k];
      if (pop[k]) out_d[k*bw +: bw] = mem_q[k][rptr_q[k][AW-1:0]];
      // Status is computed from next-state pointers so the registered flags track occupancy exactly.
      if ((wptr_d[k][AW] != rptr_d[k][AW]) && (wptr_d[k][AW-1:0] == rptr_d[k][AW-1:0]))
        full_d = 1'b1;
      if (wptr_d[k] != rptr_d[k])
        empty_d = 1'b0;
    end
    valid_d = pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < row; k++) begin
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
      end
      out_q   <= '0;
      valid_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      for (int unsigned k = 0; k < row; k++) begin
        wptr_q[k] <= wptr_d[k];
        rptr_q[k] <= rptr_d[k];
      end
      out_q   <= out_d;
      valid_q <= valid_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      for (int unsigned k = 0; k < row; k++) begin
        mem_q[k][wptr_q[k][AW-1:0]] <= in[k*bw +: bw];
      end
    end
  end

  assign out     = out_q;
  assign o_valid = valid_q;
  assign o_full  = full_q;
  assign o_ready = ~full_q;
  assign o_empty = empty_q;

endmodule

// File: tb/tb_l0_input_buffer.sv
// Randomized scoreboard bench for l0_input_buffer: a queue-based reference model predicts pops and flags,
// a negedge monitor compares every row, every cycle.
module tb_l0_input_buffer;

  localparam int BW    = 4;
  localparam int ROW   = 8;
  localparam int DEPTH = 64;
`ifdef L0_SKEW_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif

  logic              clk;
  logic              reset;
  logic              wr;
  logic              rd;
  logic [ROW*BW-1:0] din;
  logic [ROW*BW-1:0] dout;
  logic [ROW-1:0]    o_valid;
  logic              o_full;
  logic              o_ready;
  logic              o_empty;

  l0_input_buffer #(.bw(BW), .row(ROW), .depth(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .in      (din),
    .rd      (rd),
    .out     (dout),
    .o_valid (o_valid),
    .o_full  (o_full),
    .o_ready (o_ready),
    .o_empty (o_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int cyc; logic [BW-1:0] d; } rec_t;
  typedef struct { int cyc; bit full; bit empty; bit rst; } st_t;

  rec_t          exp_q [ROW][$];
  st_t           st_q[$];
  logic [BW-1:0] fifo  [ROW][$];
  int            pend  [ROW][$];
  int            cyc = 0;
  bit            started = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  bit            m_full, m_empty;
  logic [BW-1:0] m_d;
  rec_t          m_rec;

  // Reference model: each edge, pops use pre-edge occupancy, write is gated by pre-edge fullness.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      started = 1;
      for (int k = 0; k < ROW; k++) begin
        fifo[k].delete();
        pend[k].delete();
        exp_q[k].delete();
      end
      st_q.push_back('{cyc, 1'b0, 1'b1, 1'b1});
    end else if (started) begin
      m_full = 0;
      for (int k = 0; k < ROW; k++) if (fifo[k].size() == DEPTH) m_full = 1;
      if (rd) for (int k = 0; k < ROW; k++) pend[k].push_back(cyc + SKEW * k);
      for (int k = 0; k < ROW; k++) begin
        if (pend[k].size() > 0 && pend[k][0] == cyc) begin
          void'(pend[k].pop_front());
          if (fifo[k].size() > 0) begin
            m_d = fifo[k].pop_front();
            exp_q[k].push_back('{cyc, m_d});
          end
        end
      end
      if (wr && !m_full)
        for (int k = 0; k < ROW; k++) fifo[k].push_back(din[k*BW +: BW]);
      m_full  = 0;
      m_empty = 1;
      for (int k = 0; k < ROW; k++) begin
        if (fifo[k].size() == DEPTH) m_full = 1;
        if (fifo[k].size() != 0)     m_empty = 0;
      end
      st_q.push_back('{cyc, m_full, m_empty, 1'b0});
    end
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, k, cyc, act, expv);
    end
  endtask

  logic [BW-1:0] hold [ROW];
  st_t           mon_st;

  always @(negedge clk) begin
    if (started) begin
      if (st_q.size() == 0) begin
        chk("status_queue_empty", 0, 1, 0);
      end else begin
        mon_st = st_q.pop_front();
        chk("o_full",  0, 32'(o_full),  32'(mon_st.full));
        chk("o_ready", 0, 32'(o_ready), 32'(!mon_st.full));
        chk("o_empty", 0, 32'(o_empty), 32'(mon_st.empty));
        if (mon_st.rst) for (int k = 0; k < ROW; k++) hold[k] = '0;
      end
      for (int k = 0; k < ROW; k++) begin
        if (exp_q[k].size() > 0 && exp_q[k][0].cyc == cyc) begin
          m_rec = exp_q[k].pop_front();
          chk("o_valid_hi", k, 32'(o_valid[k]), 32'd1);
          chk("lane_data", k, 32'(dout[k*BW +: BW]), 32'(m_rec.d));
          hold[k] = m_rec.d;
        end else begin
          chk("o_valid_lo", k, 32'(o_valid[k]), 32'd0);
          chk("lane_hold", k, 32'(dout[k*BW +: BW]), 32'(hold[k]));
        end
      end
    end
  end

  task automatic step(input bit r, input bit w, input logic [31:0] d, input bit ri);
    reset = r;
    wr    = w;
    din   = d;
    rd    = ri;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0);
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; din = '0;
    @(posedge clk); #1;
    step(1, 0, '0, 0);
    idle(3);

    // single word, one wave
    step(0, 1, 32'h7654_3210, 0);
    idle(1);
    step(0, 0, '0, 1);
    idle(12);

    // fill to full, overflow write ignored, then drain in order
    for (int i = 0; i < DEPTH; i++) step(0, 1, $urandom, 0);
    step(0, 1, 32'hFFFF_FFFF, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, '0, 1);
    idle(12);
    for (int i = 0; i < 40; i++) step(0, 1, $urandom, i[0]);
    for (int i = 0; i < 40; i++) step(0, 0, '0, 1);
    idle(12);

    // reads on an empty buffer
    step(1, 0, '0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, '0, 1);
    idle(3);

    // full buffer with same-edge write and read
    for (int i = 0; i < DEPTH; i++) step(0, 1, $urandom, 0);
    for (int i = 0; i < 10; i++) step(0, 1, $urandom, 1);
    for (int i = 0; i < 4; i++) step(0, 1, $urandom, 0);
    for (int i = 0; i < 80; i++) step(0, 0, '0, 1);
    idle(12);

    // wave aborted by reset
    for (int i = 0; i < 3; i++) step(0, 1, $urandom, 0);
    step(0, 0, '0, 1);
    idle(2);
    step(1, 0, '0, 0);
    idle(12);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 45);
    for (int i = 0; i < 80; i++) step(0, 0, '0, 1);
    idle(20);

    for (int k = 0; k < ROW; k++) chk("exp_q_drained", k, exp_q[k].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
